// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the serial pattern generator.
// The PARITY state exists in the type for both builds; only SEQ_GEN_PARITY_EN enters it.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } seq_state_t;

  localparam logic [3:0] SEQ_DEF_PAT = 4'b1010;

endpackage

// File: rtl/seq_gen_ctr.sv
// Loadable down-counter with a zero flag, used for bit index and frame repetitions.
module seq_gen_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/seq_gen_tx.sv
// Serial pattern transmitter: MSB-first frames repeated max(reps,1) times, then a done pulse.
// Define SEQ_GEN_PARITY_EN to append an even-parity bit to every frame.
//
//   state  | meaning
//   IDLE   | waiting for start; outputs quiet
//   SHIFT  | emitting pattern bits, MSB first
//   PARITY | emitting the even-parity bit of the frame
//   DONE   | one-cycle done pulse, then IDLE
module seq_gen_tx
  import seq_gen_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter int               CNT_W   = 4,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(SEQ_DEF_PAT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pat_sel,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] reps,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;

  seq_state_t       state_q, state_d;
  logic [PAT_W-1:0] shift_q, shift_d;
  logic             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             bit_load, bit_dec, bit_zero;
  logic             rep_load, rep_dec, rep_zero;
  logic [CNT_W-1:0] rep_load_val;

  // Rep counter holds frames remaining after the current one; reps=0 behaves as 1.
  assign rep_load_val = (reps == '0) ? '0 : CNT_W'(reps - CNT_W'(1));

  seq_gen_ctr #(.W(BIT_W)) u_bit_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (bit_load),
    .dec      (bit_dec),
    .load_val (BIT_W'(PAT_W - 1)),
    .zero     (bit_zero)
  );

  seq_gen_ctr #(.W(CNT_W)) u_rep_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (rep_load),
    .dec      (rep_dec),
    .load_val (rep_load_val),
    .zero     (rep_zero)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_load    = 1'b0;
    bit_dec     = 1'b0;
    rep_load    = 1'b0;
    rep_dec     = 1'b0;
    out_d       = 1'b0;
    out_valid_d = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d  = pat_sel ? pattern : DEF_PAT;
          bit_load = 1'b1;
          rep_load = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        out_d       = shift_q[PAT_W-1];
        out_valid_d = 1'b1;
        // Rotating keeps the captured pattern intact for the next frame.
        shift_d     = {shift_q[PAT_W-2:0], shift_q[PAT_W-1]};
        if (!bit_zero) begin
          bit_dec = 1'b1;
        end else begin
`ifdef SEQ_GEN_PARITY_EN
          state_d = PARITY;
`else
          if (rep_zero) begin
            state_d = DONE;
          end else begin
            bit_load = 1'b1;
            rep_dec  = 1'b1;
          end
`endif
        end
      end
`ifdef SEQ_GEN_PARITY_EN
      PARITY: begin
        out_d       = ^shift_q;
        out_valid_d = 1'b1;
        if (rep_zero) begin
          state_d = DONE;
        end else begin
          bit_load = 1'b1;
          rep_dec  = 1'b1;
          state_d  = SHIFT;
        end
      end
`endif
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs trail the state by one register stage; busy covers the load cycle too.
    busy_d = (state_q != IDLE) || (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seq_gen_tx.sv
// Directed self-checking bench for seq_gen_tx; expected streams follow SEQ_GEN_PARITY_EN.
module tb_seq_gen_tx;

  logic       clk;
  logic       rst;
  logic       start;
  logic       pat_sel;
  logic [3:0] pattern;
  logic [3:0] reps;
  logic       out;
  logic       out_valid;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  seq_gen_tx dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pat_sel   (pat_sel),
    .pattern   (pattern),
    .reps      (reps),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one transfer, scramble inputs while busy, then check every cycle to idle.
  task automatic run(input string tag, input logic psel, input logic [3:0] pat,
                     input logic [3:0] nreps, input logic [31:0] exp_bits, input int nbits);
    pat_sel = psel;
    pattern = pat;
    reps    = nreps;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    pat_sel = ~psel;
    pattern = ~pat;
    reps    = nreps + 4'd5;
    chk({tag, "_load_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_load_busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < nbits; i++) begin
      tick();
      chk($sformatf("%s_bit%0d", tag, i), {29'd0, out, out_valid, done},
          {29'd0, exp_bits[nbits-1-i], 1'b1, 1'b0});
    end
    tick();
    chk({tag, "_done"}, {28'd0, out, out_valid, busy, done}, 32'b0011);
    tick();
    chk({tag, "_idle"}, {28'd0, out, out_valid, busy, done}, 32'b0000);
  endtask

  initial begin
    logic [31:0] e_def1, e_def3, e_1011x2, e_0110;
    int          n_def1, n_def3, n_1011x2, n_0110;
    int          seen;
`ifdef SEQ_GEN_PARITY_EN
    e_def1   = 32'b10100;            n_def1   = 5;
    e_def3   = 32'b101001010010100;  n_def3   = 15;
    e_1011x2 = 32'b1011110111;       n_1011x2 = 10;
    e_0110   = 32'b01100;            n_0110   = 5;
`else
    e_def1   = 32'b1010;             n_def1   = 4;
    e_def3   = 32'b101010101010;     n_def3   = 12;
    e_1011x2 = 32'b10111011;         n_1011x2 = 8;
    e_0110   = 32'b0110;             n_0110   = 4;
`endif

    rst = 1'b1; start = 1'b0; pat_sel = 1'b0; pattern = 4'h0; reps = 4'h0;
    tick(); tick();
    chk("reset_outputs", {28'd0, out, out_valid, busy, done}, 32'b0000);
    rst = 1'b0;
    tick();
    chk("idle_outputs", {28'd0, out, out_valid, busy, done}, 32'b0000);

    run("def_r1", 1'b0, 4'h0, 4'd1, e_def1, n_def1);
    run("def_r3", 1'b0, 4'h0, 4'd3, e_def3, n_def3);
    run("def_r0", 1'b0, 4'h0, 4'd0, e_def1, n_def1);
    run("usr_1011_r2", 1'b1, 4'b1011, 4'd2, e_1011x2, n_1011x2);
    run("usr_0110_r1", 1'b1, 4'b0110, 4'd1, e_0110, n_0110);

    // start held high: one transfer, then a fresh one only after passing through IDLE
    pat_sel = 1'b0; reps = 4'd1; start = 1'b1;
    tick();
    for (int i = 0; i < n_def1; i++) begin
      tick();
      chk($sformatf("hold_bit%0d", i), {30'd0, out, out_valid}, {30'd0, e_def1[n_def1-1-i], 1'b1});
    end
    tick();
    chk("hold_done", {29'd0, out_valid, busy, done}, 32'b011);
    tick();
    chk("hold_gap", {30'd0, out_valid, done}, 32'b00);
    tick();
    chk("hold_restart", {30'd0, out, out_valid}, 32'b11);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      tick();
      if (done) seen = 1;
    end
    chk("hold_second_done", 32'(seen), 32'd1);
    tick();
    chk("hold_idle", {29'd0, out_valid, busy, done}, 32'b000);

    // reset on the second bit aborts without done
    pat_sel = 1'b0; reps = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("abort_second_bit", {30'd0, out, out_valid}, 32'b01);
    rst = 1'b1;
    tick();
    chk("abort_outputs", {28'd0, out, out_valid, busy, done}, 32'b0000);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || out_valid || busy) seen = 1;
    end
    chk("abort_quiet", 32'(seen), 32'd0);
    run("after_abort", 1'b0, 4'h0, 4'd1, e_def1, n_def1);

    // reset wins over start on the same edge
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("rst_prio_1", {29'd0, out_valid, busy, done}, 32'b000);
    tick();
    chk("rst_prio_2", {29'd0, out_valid, busy, done}, 32'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_gen_tx.md
SEQ_GEN_TX -- requirements
Module: seq_gen_tx

Interface
REQ-001 Parameter PAT_W, default 4, pattern width in bits (>=2).
REQ-002 Parameter CNT_W, default 4, repetition-count width.
REQ-003 Parameter DEF_PAT, default 4'b1010 (PAT_W bits), pattern used when pat_sel=0.
REQ-004 clk  input  1  sole clock, all state updates on posedge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  request to transmit; sampled only in IDLE.
REQ-007 pat_sel  input  1  0: send DEF_PAT; 1: send pattern input.
REQ-008 pattern  input  PAT_W  user pattern, captured on accepted start.
REQ-009 reps  input  CNT_W  frame repetitions, captured on accepted start.
REQ-010 out  output  1  serial bit stream, registered.
REQ-011 out_valid  output  1  high while out carries a pattern or parity bit.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  single-cycle pulse after last bit of last frame.

Function
REQ-014 States SHALL be IDLE, SHIFT, PARITY, DONE; all outputs registered (Moore).
REQ-015 In IDLE with start=1 at edge T, the block SHALL capture the selected pattern and reps and present pattern MSB on out with out_valid=1 after edge T+1 (latency 1).
REQ-016 SHIFT SHALL emit one bit per cycle, MSB first, PAT_W cycles per frame.
REQ-017 After the frame LSB: PARITY if parity enabled, else next frame or DONE.
REQ-018 PARITY SHALL last one cycle, out = XOR of all captured pattern bits (even parity), out_valid=1.
REQ-019 Frames SHALL be back-to-back with no idle gap; a rep counter SHALL decrement per completed frame.
REQ-020 reps=0 SHALL be treated as 1.
REQ-021 Total valid cycles SHALL equal max(reps,1)*(PAT_W+P), P=1 with parity, else 0.
REQ-022 DONE SHALL last exactly one cycle: done=1, out=0, out_valid=0, busy=1; then IDLE.
REQ-023 start SHALL be ignored in SHIFT, PARITY and DONE; no queuing.
REQ-024 Changes on pattern, pat_sel or reps while busy SHALL have no effect.
REQ-025 In IDLE: out=0, out_valid=0, busy=0, done=0.

Reset
REQ-026 rst=1 at any edge SHALL force IDLE, clear shift register and counters, drive out=0, out_valid=0, busy=0, done=0.
REQ-027 Reset mid-frame SHALL abort without a done pulse; a start after rst deasserts SHALL be accepted normally.
REQ-028 rst SHALL have priority over start on the same edge.

Configuration
REQ-029 Macro SEQ_GEN_PARITY_EN defined: PARITY state and parity bit per frame present.
REQ-030 Macro SEQ_GEN_PARITY_EN undefined: PARITY state, parity logic absent; frame is PAT_W bits.

Structure
REQ-031 Package seq_gen_pkg SHALL hold the state typedef (IDLE, SHIFT, PARITY, DONE) and DEF_PAT default constant.
REQ-032 Sub-module seq_gen_ctr SHALL implement the bit-index and repetition down-counters with load/decrement/zero-flag.

Verification
REQ-033 Default build, pat_sel=0, reps=1, start pulse -> out 1,0,1,0 with out_valid high 4 cycles, done pulse on cycle 5, busy low cycle 6.
REQ-034 pat_sel=0, reps=3 -> 12 contiguous valid bits 101010101010, single done pulse after.
REQ-035 reps=0 -> identical to reps=1 (4 valid bits, one done).
REQ-036 start held high throughout a 4-bit frame -> one transfer only; new start accepted only after return to IDLE.
REQ-037 rst asserted on second bit of frame -> next cycle all outputs 0, no done; subsequent start sends full frame.
REQ-038 SEQ_GEN_PARITY_EN, pat_sel=1, pattern=4'b1011, reps=2 -> out 1,0,1,1,1,1,0,1,1,1 then done.
